// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 codes, size decode.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RMW_WR = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    lsu_size_e size;
    logic      sext;
  } lsu_dec_t;

  typedef struct packed {
    logic            write;
    lsu_dec_t        dec;
    logic [1:0]      lane;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Reserved funct3 encodings fall through to a full word access.
  function automatic lsu_dec_t decode_size(input logic [2:0] funct3);
    lsu_dec_t d;
    d.size = SZ_W;
    d.sext = 1'b0;
    case (funct3)
      F3_B:    begin d.size = SZ_B; d.sext = 1'b1; end
      F3_H:    begin d.size = SZ_H; d.sext = 1'b1; end
      F3_BU:   begin d.size = SZ_B; d.sext = 1'b0; end
      F3_HU:   begin d.size = SZ_H; d.sext = 1'b0; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      lane_i,
  input  lsu_size_e       size_i,
  input  logic            sext_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o
);

  logic [4:0]      shamt;
  logic [15:0]     shifted;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] ins;

  always_comb begin
    shamt   = (size_i == SZ_H) ? {lane_i[1], 4'b0000} : {lane_i, 3'b000};
    shifted = 16'(word_i >> shamt);
    load_o  = word_i;
    mask    = '1;
    ins     = wdata_i;
    case (size_i)
      SZ_B: begin
        load_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
        mask   = XLEN'(32'h0000_00FF) << shamt;
        ins    = XLEN'(wdata_i[7:0]) << shamt;
      end
      SZ_H: begin
        load_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
        mask   = XLEN'(32'h0000_FFFF) << shamt;
        ins    = XLEN'(wdata_i[15:0]) << shamt;
      end
      default: ;
    endcase
    merge_o = (word_i & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, RMW for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses via done_err_o.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [2:0]                req_funct3_i,
  input  logic [31:0]               req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      done_valid_o,
  output logic [DATA_WIDTH-1:0]     done_rdata_o,
  output logic                      done_err_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0]     mem_writedata_o,
  output logic                      mem_memwrite_o,
  output logic                      mem_memread_o,
  input  logic [DATA_WIDTH-1:0]     mem_readdata_i
);

  lsu_state_e                state_q, state_d;
  lsu_req_t                  req_q, req_d;
  logic [MEM_ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [DATA_WIDTH-1:0]     old_q, old_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  lsu_dec_t                  dec_in;
  logic [1:0]                lane_in;
  logic                      wr_c, rd_c;
  logic [DATA_WIDTH-1:0]     wdata_c, align_word, load_w, merge_w;
  logic                      unused_addr_hi;

  assign dec_in         = decode_size(req_funct3_i);
  assign unused_addr_hi = ^req_addr_i[31:MEM_ADDR_WIDTH+2];

  // Low address bits that cannot be honoured for the access size are dropped.
  always_comb begin
    lane_in = req_addr_i[1:0];
    if (dec_in.size == SZ_H) lane_in[0] = 1'b0;
    if (dec_in.size == SZ_W) lane_in    = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q, err_d;
  logic misalign;
  assign misalign = ((dec_in.size == SZ_H) && req_addr_i[0]) ||
                    ((dec_in.size == SZ_W) && (req_addr_i[1:0] != 2'b00));
  assign done_err_o = err_q;
`else
  assign done_err_o = 1'b0;
`endif

  assign align_word = (state_q == ST_RMW_WR) ? old_q : mem_readdata_i;

  lsu_lane_align u_align (
    .word_i  (align_word),
    .lane_i  (req_q.lane),
    .size_i  (req_q.dec.size),
    .sext_i  (req_q.dec.sext),
    .wdata_i (req_q.wdata),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      widx_q  <= '0;
      old_q   <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      widx_q  <= widx_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    widx_d  = widx_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    wr_c    = 1'b0;
    rd_c    = 1'b0;
    wdata_c = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          req_d.write = req_write_i;
          req_d.dec   = dec_in;
          req_d.lane  = lane_in;
          req_d.wdata = req_wdata_i;
          widx_d      = req_addr_i[MEM_ADDR_WIDTH+1:2];
          state_d     = ST_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
          err_d = misalign;
          if (misalign) begin
            state_d = ST_DONE;
            rdata_d = '0;
          end
`endif
        end
      end
      ST_ACCESS: begin
        if (!req_q.write) begin
          rd_c    = 1'b1;
          rdata_d = load_w;
          state_d = ST_DONE;
        end else if (req_q.dec.size == SZ_W) begin
          wr_c    = 1'b1;
          wdata_c = req_q.wdata;
          rdata_d = '0;
          state_d = ST_DONE;
        end else begin
          rd_c    = 1'b1;
          old_d   = mem_readdata_i;
          state_d = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        wr_c    = 1'b1;
        wdata_c = merge_w;
        rdata_d = '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign done_valid_o    = (state_q == ST_DONE);
  assign done_rdata_o    = rdata_q;
  assign mem_address_o   = (state_q == ST_IDLE) ? '0 : widx_q;
  assign mem_writedata_o = wdata_c;
  // Strobes are killed by reset so an interrupted RMW never lands a write.
  assign mem_memwrite_o  = wr_c & ~reset;
  assign mem_memread_o   = rd_c & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural 1024-word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready_o;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done_valid_o;
  logic [31:0] done_rdata_o;
  logic        done_err_o;
  logic [9:0]  mem_address_o;
  logic [31:0] mem_writedata_o;
  logic        mem_memwrite_o;
  logic        mem_memread_o;
  logic [31:0] mem_readdata;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .req_write_i     (req_write),
    .req_funct3_i    (req_funct3),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .done_valid_o    (done_valid_o),
    .done_rdata_o    (done_rdata_o),
    .done_err_o      (done_err_o),
    .mem_address_o   (mem_address_o),
    .mem_writedata_o (mem_writedata_o),
    .mem_memwrite_o  (mem_memwrite_o),
    .mem_memread_o   (mem_memread_o),
    .mem_readdata_i  (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_readdata = mem_memread_o ? mem[mem_address_o] : 32'h0;
  always @(posedge clk) if (mem_memwrite_o) mem[mem_address_o] <= mem_writedata_o;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rd;
    int          nrd;
    int          nwr;
    int          idx;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int nrd, output int nwr, output int rdy_busy);
    logic got;
    @(negedge clk);
    check("ready_idle", 32'(req_ready_o), 32'h1);
    check("addr_idle", 32'(mem_address_o), 32'h0);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_funct3 = ~f3; req_addr = ~a; req_wdata = ~wd;
    lat = 0; rd = 32'h0; er = 1'b0; nrd = 0; nwr = 0; rdy_busy = 0; got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (mem_memread_o) nrd++;
      if (mem_memwrite_o) nwr++;
      if (done_valid_o) begin
        rd = done_rdata_o; er = done_err_o; got = 1'b1;
        if (req_ready_o) rdy_busy++;
        break;
      end
      if (req_ready_o) rdy_busy++;
    end
    check("done_seen", 32'(got), 32'h1);
  endtask

  initial begin
    int lat, nrd, nwr, rb, acc, ndone, nwr_hs, bad_rdy;
    logic [31:0] rd, rd2;
    logic er;

    vecs[0]  = '{1'b1, F3_W,   32'h10,   32'hDEADBEEF, 2, 32'h0,        0, 1, 4, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, F3_W,   32'h10,   32'h0,        2, 32'hDEADBEEF, 1, 0, 4, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, F3_W,   32'h10,   32'h11223344, 2, 32'h0,        0, 1, 4, 32'h11223344};
    vecs[3]  = '{1'b1, F3_B,   32'h11,   32'hFFFFFFAA, 3, 32'h0,        1, 1, 4, 32'h1122AA44};
    vecs[4]  = '{1'b0, F3_B,   32'h11,   32'h0,        2, 32'hFFFFFFAA, 1, 0, 4, 32'h1122AA44};
    vecs[5]  = '{1'b0, F3_BU,  32'h11,   32'h0,        2, 32'h000000AA, 1, 0, 4, 32'h1122AA44};
    vecs[6]  = '{1'b1, F3_W,   32'h10,   32'h11223344, 2, 32'h0,        0, 1, 4, 32'h11223344};
    vecs[7]  = '{1'b1, F3_H,   32'h12,   32'hABCD8001, 3, 32'h0,        1, 1, 4, 32'h80013344};
    vecs[8]  = '{1'b0, F3_H,   32'h12,   32'h0,        2, 32'hFFFF8001, 1, 0, 4, 32'h80013344};
    vecs[9]  = '{1'b0, F3_HU,  32'h12,   32'h0,        2, 32'h00008001, 1, 0, 4, 32'h80013344};
    vecs[10] = '{1'b0, F3_B,   32'h13,   32'h0,        2, 32'hFFFFFF80, 1, 0, 4, 32'h80013344};
    vecs[11] = '{1'b0, F3_H,   32'h10,   32'h0,        2, 32'h00003344, 1, 0, 4, 32'h80013344};
    vecs[12] = '{1'b1, F3_W,   32'h1010, 32'h5A5A0001, 2, 32'h0,        0, 1, 4, 32'h5A5A0001};
    vecs[13] = '{1'b0, 3'b011, 32'h10,   32'h0,        2, 32'h5A5A0001, 1, 0, 4, 32'h5A5A0001};
    vecs[14] = '{1'b1, F3_B,   32'h13,   32'h123456FF, 3, 32'h0,        1, 1, 4, 32'hFF5A0001};
    vecs[15] = '{1'b0, F3_B,   32'h12,   32'h0,        2, 32'h0000005A, 1, 0, 4, 32'hFF5A0001};
    vecs[16] = '{1'b0, F3_BU,  32'h13,   32'h0,        2, 32'h000000FF, 1, 0, 4, 32'hFF5A0001};
    vecs[17] = '{1'b0, 3'b111, 32'h1010, 32'h0,        2, 32'hFF5A0001, 1, 0, 4, 32'hFF5A0001};
    vecs[18] = '{1'b1, F3_B,   32'h10,   32'h00000080, 3, 32'h0,        1, 1, 4, 32'hFF5A0080};
    vecs[19] = '{1'b0, F3_B,   32'h10,   32'h0,        2, 32'hFFFFFF80, 1, 0, 4, 32'hFF5A0080};
    vecs[20] = '{1'b0, F3_HU,  32'h12,   32'h0,        2, 32'h0000FF5A, 1, 0, 4, 32'hFF5A0080};
    vecs[21] = '{1'b0, F3_H,   32'h12,   32'h0,        2, 32'hFFFFFF5A, 1, 0, 4, 32'hFF5A0080};
    vecs[22] = '{1'b1, F3_H,   32'h10,   32'h00001234, 3, 32'h0,        1, 1, 4, 32'hFF5A1234};
    vecs[23] = '{1'b0, F3_HU,  32'h10,   32'h0,        2, 32'h00001234, 1, 0, 4, 32'hFF5A1234};
    vecs[24] = '{1'b0, 3'b110, 32'h10,   32'h0,        2, 32'hFF5A1234, 1, 0, 4, 32'hFF5A1234};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'h1);
    check("rst_done_valid", 32'(done_valid_o), 32'h0);
    check("rst_rdata", done_rdata_o, 32'h0);
    check("rst_err", 32'(done_err_o), 32'h0);
    check("rst_strobes", {30'h0, mem_memwrite_o, mem_memread_o}, 32'h0);
    check("rst_addr", 32'(mem_address_o), 32'h0);
    check("rst_wdata", mem_writedata_o, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      run_req(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, er, nrd, nwr, rb);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      check($sformatf("v%0d_err", i), 32'(er), 32'h0);
      check($sformatf("v%0d_reads", i), 32'(nrd), 32'(vecs[i].nrd));
      check($sformatf("v%0d_writes", i), 32'(nwr), 32'(vecs[i].nwr));
      check($sformatf("v%0d_ready_busy", i), 32'(rb), 32'h0);
      check($sformatf("v%0d_mem", i), mem[vecs[i].idx], vecs[i].word);
    end

    // done_rdata holds after a load while idle
    @(negedge clk);
    check("rdata_hold", done_rdata_o, 32'hFF5A1234);

    // Misaligned accesses; memory word 4 holds 0xFF5A1234
    run_req(1'b0, F3_W, 32'h13, 32'h0, lat, rd, er, nrd, nwr, rb);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lw_err", 32'(er), 32'h1);
    check("mis_lw_lat", 32'(lat), 32'h1);
    check("mis_lw_rdata", rd, 32'h0);
    check("mis_lw_reads", 32'(nrd), 32'h0);
    @(negedge clk);
    check("mis_err_clear", 32'(done_err_o), 32'h0);
`else
    check("mis_lw_err", 32'(er), 32'h0);
    check("mis_lw_lat", 32'(lat), 32'h2);
    check("mis_lw_rdata", rd, 32'hFF5A1234);
    check("mis_lw_reads", 32'(nrd), 32'h1);
`endif
    run_req(1'b1, F3_H, 32'h11, 32'h0000BEEF, lat, rd, er, nrd, nwr, rb);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_sh_err", 32'(er), 32'h1);
    check("mis_sh_writes", 32'(nwr), 32'h0);
    check("mis_sh_mem", mem[4], 32'hFF5A1234);
`else
    check("mis_sh_err", 32'(er), 32'h0);
    check("mis_sh_lat", 32'(lat), 32'h3);
    check("mis_sh_mem", mem[4], 32'hFF5ABEEF);
`endif

    // Handshake: req_valid held high across two requests, inputs changed after accept
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    acc = 1; ndone = 0; nwr_hs = 0; bad_rdy = 0; rd2 = 32'h0;
    @(posedge clk);
    #1;
    req_write = 1'b0; req_wdata = 32'h0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_memwrite_o) nwr_hs++;
      if (done_valid_o) begin
        ndone++;
        rd2 = done_rdata_o;
        if (req_ready_o) bad_rdy++;
      end
      if (req_ready_o) begin
        if (acc == 2) req_valid = 1'b0;
        else acc++;
      end
    end
    req_valid = 1'b0;
    check("hs_done_pulses", 32'(ndone), 32'h2);
    check("hs_writes", 32'(nwr_hs), 32'h1);
    check("hs_ready_in_done", 32'(bad_rdy), 32'h0);
    check("hs_mem", mem[8], 32'hCAFEF00D);
    check("hs_load_rdata", rd2, 32'hCAFEF00D);

    // Reset asserted while in RMW_WR
    run_req(1'b1, F3_W, 32'h30, 32'h01020304, lat, rd, er, nrd, nwr, rb);
    check("rmw_pre_mem", mem[12], 32'h01020304);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B; req_addr = 32'h31; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rmw_access_read", 32'(mem_memread_o), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rmw_rst_write", 32'(mem_memwrite_o), 32'h0);
    check("rmw_rst_done", 32'(done_valid_o), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rmw_rst_mem", mem[12], 32'h01020304);
    check("rmw_rst_ready", 32'(req_ready_o), 32'h1);
    check("rmw_rst_addr", 32'(mem_address_o), 32'h0);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      if (done_valid_o) ndone++;
      @(negedge clk);
    end
    check("rmw_rst_no_done", 32'(ndone), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
